// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard sequencer.
// Latency: n/a (types, constants and a pure combinational helper).
// Backpressure: n/a.
//
// Contents: FSM state encoding, NOP instruction word, register-field width,
// and the load-use hazard detect function.
package pipe_ctrl_pkg;

  localparam int          REG_W     = 5;
  localparam logic [31:0] NOP_INSTR = 32'h0;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_LU_STALL = 2'd1,
    ST_BR_FLUSH = 2'd2,
    ST_MEM_WAIT = 2'd3
  } state_e;

  // A load into $0 never creates a dependency, since $0 always reads as zero.
  function automatic logic lu_hazard(
    input logic             ex_memread,
    input logic [REG_W-1:0] ex_rt,
    input logic [REG_W-1:0] id_rs,
    input logic [REG_W-1:0] id_rt,
    input logic             id_uses_rs,
    input logic             id_uses_rt
  );
    return ex_memread && (ex_rt != '0) &&
           ((id_uses_rs && (id_rs == ex_rt)) || (id_uses_rt && (id_rt == ex_rt)));
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter for performance debug.
// Latency: count reflects an increment one clock after inc is sampled.
// Backpressure: none; clr wins over inc, count sticks at all-ones.
//
// Ports: clk, rst (async, active-high), clr (sync clear), inc (count this
// cycle), cnt_o (current count).
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for a 5-stage pipeline (load-use, taken branch, dmem wait).
// Latency: control outputs are combinational from state and current inputs.
// Backpressure: dmem_busy freezes the whole pipe; the interrupted sequence resumes after.
//
// Ports:
//   clk, rst                 clock, async active-high reset
//   ID_rs/ID_rt/ID_uses_*    source operands of the instruction in ID
//   EX_memread/EX_rt         load in EX and its destination
//   EX_br_taken              taken branch/jump resolved in EX
//   dmem_busy                MEM-stage access not yet complete
//   cnt_clr                  sync clear of the performance counters
//   pc_we .. mem_wb_bubble   per-register advance/hold/squash controls
//   stall_cycles/flush_cycles saturating perf counters, state_o debug state
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int LU_BUBBLES      = 1,
  parameter int BR_FLUSH_CYCLES = 1,
  parameter int CNT_W           = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       ID_rs,
  input  logic [4:0]       ID_rt,
  input  logic             ID_uses_rs,
  input  logic             ID_uses_rt,
  input  logic             EX_memread,
  input  logic [4:0]       EX_rt,
  input  logic             EX_br_taken,
  input  logic             dmem_busy,
  input  logic             cnt_clr,
  output logic             pc_we,
  output logic             if_id_stall,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             ex_mem_hold,
  output logic             mem_wb_bubble,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_cycles,
  output logic [1:0]       state_o
);

  // The first bubble/flush cycle is issued from RUN, so the dedicated state
  // only has to cover the remaining N-1 cycles (cnt counts down to 0).
  localparam logic [2:0] LU_INIT   = 3'(LU_BUBBLES - 2);
  localparam logic [2:0] BR_INIT   = 3'(BR_FLUSH_CYCLES - 2);
  // A branch caught during a freeze has not flushed anything yet, so the
  // whole flush sequence runs from BR_FLUSH after the freeze.
  localparam logic [2:0] BR_RESUME = 3'(BR_FLUSH_CYCLES - 1);

  state_e     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  state_e     resume_state_q, resume_state_d;
  logic [2:0] resume_cnt_q, resume_cnt_d;

  state_e     eff_state;
  logic [2:0] eff_cnt;
  logic       lu_haz;

  logic pc_we_c, if_id_stall_c, if_id_flush_c;
  logic id_ex_bubble_c, ex_mem_hold_c, mem_wb_bubble_c;

  assign lu_haz = lu_hazard(EX_memread, EX_rt, ID_rs, ID_rt, ID_uses_rs, ID_uses_rt);

  // Leaving MEM_WAIT: this cycle behaves exactly like the saved state.
  always_comb begin
    eff_state = state_q;
    eff_cnt   = cnt_q;
    if (state_q == ST_MEM_WAIT) begin
      eff_state = resume_state_q;
      eff_cnt   = resume_cnt_q;
    end
  end

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    resume_state_d  = resume_state_q;
    resume_cnt_d    = resume_cnt_q;
    pc_we_c         = 1'b1;
    if_id_stall_c   = 1'b0;
    if_id_flush_c   = 1'b0;
    id_ex_bubble_c  = 1'b0;
    ex_mem_hold_c   = 1'b0;
    mem_wb_bubble_c = 1'b0;

    if (dmem_busy) begin
      pc_we_c         = 1'b0;
      if_id_stall_c   = 1'b1;
      ex_mem_hold_c   = 1'b1;
      mem_wb_bubble_c = 1'b1;
      state_d         = ST_MEM_WAIT;
      if (EX_br_taken) begin
        resume_state_d = ST_BR_FLUSH;
        resume_cnt_d   = BR_RESUME;
      end else if (state_q != ST_MEM_WAIT) begin
        // Only capture on entry; a continued freeze keeps the original.
        resume_state_d = state_q;
        resume_cnt_d   = cnt_q;
      end
    end else if (EX_br_taken) begin
      if_id_flush_c  = 1'b1;
      id_ex_bubble_c = 1'b1;
      if (BR_FLUSH_CYCLES > 1) begin
        state_d = ST_BR_FLUSH;
        cnt_d   = BR_INIT;
      end else begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end
    end else begin
      case (eff_state)
        ST_BR_FLUSH: begin
          if_id_flush_c = 1'b1;
          if (eff_cnt == '0) begin
            state_d = ST_RUN;
            cnt_d   = '0;
          end else begin
            state_d = ST_BR_FLUSH;
            cnt_d   = eff_cnt - 1'b1;
          end
        end
        ST_LU_STALL: begin
          pc_we_c        = 1'b0;
          if_id_stall_c  = 1'b1;
          id_ex_bubble_c = 1'b1;
          if (eff_cnt == '0) begin
            state_d = ST_RUN;
            cnt_d   = '0;
          end else begin
            state_d = ST_LU_STALL;
            cnt_d   = eff_cnt - 1'b1;
          end
        end
        default: begin
          state_d = ST_RUN;
          cnt_d   = '0;
          if (lu_haz) begin
            pc_we_c        = 1'b0;
            if_id_stall_c  = 1'b1;
            id_ex_bubble_c = 1'b1;
            if (LU_BUBBLES > 1) begin
              state_d = ST_LU_STALL;
              cnt_d   = LU_INIT;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_RUN;
      cnt_q          <= '0;
      resume_state_q <= ST_RUN;
      resume_cnt_q   <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      resume_state_q <= resume_state_d;
      resume_cnt_q   <= resume_cnt_d;
    end
  end

  // Force the idle pattern while reset is held so nothing is squashed.
  assign pc_we         = rst | pc_we_c;
  assign if_id_stall   = ~rst & if_id_stall_c;
  assign if_id_flush   = ~rst & if_id_flush_c;
  assign id_ex_bubble  = ~rst & id_ex_bubble_c;
  assign ex_mem_hold   = ~rst & ex_mem_hold_c;
  assign mem_wb_bubble = ~rst & mem_wb_bubble_c;
  assign state_o       = state_q;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .inc   (~pc_we),
    .cnt_o (stall_cycles)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .inc   (if_id_flush),
    .cnt_o (flush_cycles)
  );

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage pipeline. Decides each cycle whether the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB registers advance, hold, or are squashed. It covers three cases: load-use hazards, taken branches resolved in EX, and multi-cycle data-memory waits. It also keeps saturating stall and flush cycle counters for performance debug.

Parameters:
LU_BUBBLES, 1, number of bubble cycles inserted per load-use hazard (1..7).
BR_FLUSH_CYCLES, 1, number of cycles IF/ID is flushed after a taken branch (1..7).
CNT_W, 32, width of the performance counters.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  asynchronous, active-high reset.
ID_rs  in  5  rs field of the instruction in ID.
ID_rt  in  5  rt field of the instruction in ID.
ID_uses_rs  in  1  the ID instruction reads rs.
ID_uses_rt  in  1  the ID instruction reads rt.
EX_memread  in  1  the instruction in EX is a load.
EX_rt  in  5  destination register of the load in EX.
EX_br_taken  in  1  a branch/jump in EX resolved taken (one-cycle pulse).
dmem_busy  in  1  data memory has not completed the MEM-stage access.
cnt_clr  in  1  synchronous clear of both counters.
pc_we  out  1  PC write enable.
if_id_stall  out  1  IF/ID holds its contents.
if_id_flush  out  1  IF/ID loads a NOP (instruction 0); pc fields are don't-care.
id_ex_bubble  out  1  ID/EX loads control-zero (bubble).
ex_mem_hold  out  1  EX/MEM holds its contents.
mem_wb_bubble  out  1  MEM/WB loads control-zero.
stall_cycles  out  CNT_W  saturating count of cycles with pc_we=0.
flush_cycles  out  CNT_W  saturating count of cycles with if_id_flush=1.
state_o  out  2  current FSM state (debug).

Behaviour:
- States (2-bit code, stored in the shared package): RUN=0, LU_STALL=1, BR_FLUSH=2, MEM_WAIT=3. One 3-bit down-counter, cnt.
- Load-use hazard (lu_haz) = EX_memread & (EX_rt!=0) & ((ID_uses_rs & ID_rs==EX_rt) | (ID_uses_rt & ID_rt==EX_rt)).
- Outputs are combinational from state, cnt and current inputs. Evaluate in priority order: freeze > branch > load-use > run.
- Freeze (dmem_busy=1, any state):
  - pc_we=0, if_id_stall=1, id_ex_bubble=0, ex_mem_hold=1, mem_wb_bubble=1, if_id_flush=0.
  - Next state is MEM_WAIT; the state it came from and its cnt are saved in a resume register.
  - Exception: if EX_br_taken=1 in the same cycle, the resume state is BR_FLUSH with cnt=BR_FLUSH_CYCLES-1, and the first flush cycle is performed after the freeze.
- MEM_WAIT with dmem_busy=0: that cycle acts as the resumed state, re-evaluated with current inputs.
- Branch (EX_br_taken=1, no freeze):
  - if_id_flush=1, id_ex_bubble=1, pc_we=1.
  - If BR_FLUSH_CYCLES>1: go to BR_FLUSH with cnt=BR_FLUSH_CYCLES-2; otherwise go to RUN.
  - A branch overrides load-use and any LU_STALL in progress.
- BR_FLUSH: if_id_flush=1, id_ex_bubble=0, pc_we=1. When cnt==0 go to RUN, else decrement cnt.
- Load-use (lu_haz in RUN, no freeze, no branch):
  - pc_we=0, if_id_stall=1, id_ex_bubble=1.
  - If LU_BUBBLES>1: go to LU_STALL with cnt=LU_BUBBLES-2; otherwise stay in RUN.
- LU_STALL: same outputs as load-use. When cnt==0 go to RUN, else decrement cnt.
- RUN with no event: pc_we=1, all other control outputs 0.
- if_id_stall and if_id_flush are never both 1.
- Counters:
  - stall_cycles increments every cycle pc_we=0.
  - flush_cycles increments every cycle if_id_flush=1.
  - Both saturate at all-ones. cnt_clr has priority over increment.
- Reset: state=RUN, cnt=0, resume=RUN, counters=0. Combinational outputs during reset are pc_we=1, all others 0.
  - Reset asserted mid-stall or mid-flush aborts immediately, with no pending flush after release.

Decomposition:
- Package pipe_ctrl_pkg: state encodings, NOP instruction constant (32'h0), register-field width (5).
- One sub-module, sat_counter (parameter CNT_W; inputs clr, inc), instantiated twice for the counters.

Test Plan:
- Load-use, LU_BUBBLES=1: EX_memread=1, EX_rt=8, ID_rs=8, ID_uses_rs=1 for one cycle -> exactly 1 cycle of pc_we=0, if_id_stall=1, id_ex_bubble=1; stall_cycles=1.
- Load to $0: EX_rt=0 with a matching ID_rs -> no stall; pc_we stays 1.
- Branch, BR_FLUSH_CYCLES=2: EX_br_taken pulse -> cycle 0: if_id_flush=1, id_ex_bubble=1; cycle 1: if_id_flush=1 only; then RUN. flush_cycles=2.
- Branch and load-use in the same cycle -> branch response only; stall_cycles unchanged.
- dmem_busy held 3 cycles during LU_STALL (LU_BUBBLES=3) -> 3 freeze cycles, then the remaining bubbles resume. Total pc_we=0 cycles = 3 + 3 = 6.
- rst pulse mid-BR_FLUSH -> state_o=0 and counters=0 immediately; no flush after release. Saturation check with CNT_W=4: 20 stall cycles -> stall_cycles=15.
